// File: rtl/pipeline_defs.sv
// Shared definitions for the decode/operand-collect stage and its neighbours.
//   state_e     : collector FSM state encoding
//   len_e       : opcode length class (number of immediate bytes)
//   NOP_OPCODE_C: bubble opcode, also used by stage 2
package pipeline_defs;

    typedef enum logic [1:0] {
        S_OPCODE = 2'd0,
        S_LO     = 2'd1,
        S_HI     = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        LEN0 = 2'd0,
        LEN1 = 2'd1,
        LEN2 = 2'd2
    } len_e;

    localparam logic [7:0] NOP_OPCODE_C = 8'h00;

endpackage

// File: rtl/pipe_opcode_len.sv
// Opcode -> operand-count decoder. Purely combinational and kept separate so
// the class table can become a ROM without touching the collector FSM.
// Ports:
//   opcode_i : opcode byte
//   len_o    : length class (LEN0 / LEN1 / LEN2)
module pipe_opcode_len
    import pipeline_defs::*;
(
    input  logic [7:0] opcode_i,
    output len_e       len_o
);

    always_comb begin
        len_o = LEN0;
        unique case (opcode_i[7:6])
            2'b01:   len_o = LEN1;
            2'b10:   len_o = LEN2;
            default: len_o = LEN0;
        endcase
    end

endmodule

// File: rtl/pipeline_stage1.sv
// Decode/operand-collect stage between fetch and stage 2. Collects an opcode
// and its 0..2 immediate bytes, then issues them atomically on PipeOut/Imm.
// Ports:
//   ClockIn, Reset (async, active-high)
//   FetchByte/FetchValid/FetchReady : byte stream from fetch
//   Stall : stage 2 busy, freeze everything
//   Flush : drop partial instruction and pending output
//   PipeOut/PipeValid/Imm : registered issue to stage 2
//   InstrCount : issued-instruction counter (wraps)
//   Busy : a partial instruction is being collected
module pipeline_stage1
    import pipeline_defs::*;
#(
    parameter logic [7:0]  NOP_OPCODE = NOP_OPCODE_C,
    parameter int unsigned COUNT_W    = 16
) (
    input  logic               ClockIn,
    input  logic               Reset,
    input  logic [7:0]         FetchByte,
    input  logic               FetchValid,
    output logic               FetchReady,
    input  logic               Stall,
    input  logic               Flush,
    output logic [7:0]         PipeOut,
    output logic               PipeValid,
    output logic [15:0]        Imm,
    output logic [COUNT_W-1:0] InstrCount,
    output logic               Busy
);

    state_e             state_q, state_d;
    logic [7:0]         opcode_q, opcode_d;
    logic [7:0]         lo_q, lo_d;
    logic [7:0]         pipe_out_q, pipe_out_d;
    logic               pipe_valid_q, pipe_valid_d;
    logic [15:0]        imm_q, imm_d;
    logic [COUNT_W-1:0] count_q, count_d;

    logic [7:0] dec_op;
    len_e       len;

    // In S_OPCODE the incoming byte is the opcode; afterwards use the latched one.
    assign dec_op = (state_q == S_OPCODE) ? FetchByte : opcode_q;

    pipe_opcode_len u_opcode_len (
        .opcode_i (dec_op),
        .len_o    (len)
    );

    assign FetchReady = !Stall && !Reset;
    assign PipeOut    = pipe_out_q;
    assign PipeValid  = pipe_valid_q;
    assign Imm        = imm_q;
    assign InstrCount = count_q;
    assign Busy       = (state_q != S_OPCODE);

    always_comb begin
        state_d      = state_q;
        opcode_d     = opcode_q;
        lo_d         = lo_q;
        pipe_out_d   = pipe_out_q;
        pipe_valid_d = pipe_valid_q;
        imm_d        = imm_q;
        count_d      = count_q;

        if (Flush) begin
            // Flush beats Stall; the byte on this cycle is dropped.
            state_d      = S_OPCODE;
            pipe_out_d   = NOP_OPCODE;
            pipe_valid_d = 1'b0;
        end else if (!Stall) begin
            pipe_out_d   = NOP_OPCODE;
            pipe_valid_d = 1'b0;
            if (FetchValid) begin
                unique case (state_q)
                    S_OPCODE: begin
                        if (len == LEN0) begin
                            pipe_out_d   = FetchByte;
                            pipe_valid_d = 1'b1;
                            imm_d        = 16'h0000;
                            count_d      = count_q + COUNT_W'(1);
                        end else begin
                            opcode_d = FetchByte;
                            state_d  = S_LO;
                        end
                    end
                    S_LO: begin
                        if (len == LEN2) begin
                            lo_d    = FetchByte;
                            state_d = S_HI;
                        end else begin
                            pipe_out_d   = opcode_q;
                            pipe_valid_d = 1'b1;
                            imm_d        = {8'h00, FetchByte};
                            count_d      = count_q + COUNT_W'(1);
                            state_d      = S_OPCODE;
                        end
                    end
                    S_HI: begin
                        pipe_out_d   = opcode_q;
                        pipe_valid_d = 1'b1;
                        imm_d        = {FetchByte, lo_q};
                        count_d      = count_q + COUNT_W'(1);
                        state_d      = S_OPCODE;
                    end
                    default: state_d = S_OPCODE;
                endcase
            end
        end
    end

    always_ff @(posedge ClockIn or posedge Reset) begin
        if (Reset) begin
            state_q      <= S_OPCODE;
            opcode_q     <= 8'h00;
            lo_q         <= 8'h00;
            pipe_out_q   <= NOP_OPCODE;
            pipe_valid_q <= 1'b0;
            imm_q        <= 16'h0000;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            opcode_q     <= opcode_d;
            lo_q         <= lo_d;
            pipe_out_q   <= pipe_out_d;
            pipe_valid_q <= pipe_valid_d;
            imm_q        <= imm_d;
            count_q      <= count_d;
        end
    end

endmodule
